// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI SRAM bridge.
// Holds the bridge FSM states, the CPU request size codes, the spi_master
// byte_mask codes and the data helpers used on both sides of the bridge.
// The optional timeout feature is enabled by defining SPI_BRIDGE_TIMEOUT_EN.
package spi_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // CPU request size codes (code 3 behaves as a word)
  localparam logic [1:0] SIZE_BYTE     = 2'd0;
  localparam logic [1:0] SIZE_HALF     = 2'd1;
  localparam logic [1:0] SIZE_WORD     = 2'd2;
  localparam logic [1:0] SIZE_WORD_ALT = 2'd3;

  // spi_master byte_mask codes
  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  // The serial side moves the lowest-addressed byte first in the MSB lane,
  // so little-endian CPU data is byte-reversed on the way in and out.
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [1:0] size_to_mask(input logic [1:0] size);
    logic [1:0] m;
    case (size)
      SIZE_BYTE:     m = MASK_BYTE;
      SIZE_HALF:     m = MASK_HALF;
      SIZE_WORD:     m = MASK_WORD;
      SIZE_WORD_ALT: m = MASK_WORD;
      default:       m = MASK_WORD;
    endcase
    return m;
  endfunction

  // Right-align and zero-extend swapped read data to the request size.
  function automatic logic [31:0] read_extend(input logic [31:0] s, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {24'h000000, s[7:0]};
      SIZE_HALF: r = {16'h0000, s[15:0]};
      default:   r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_sram_bridge_if.sv
// Bus bundle between a CPU-side requester, the bridge and a spi_master.
//   req_*  : CPU request (valid/ready handshake, we, size, addr, wdata)
//   resp_* : one-cycle response pulse with read data and error flag
//   spi_*  : spi_master control (req active-low run), data and status
// slave modport  : used by spi_sram_bridge
// master modport : used by the environment driving requests and the spi side
interface spi_sram_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        spi_req;
  logic        spi_write;
  logic [23:0] spi_addr;
  logic [31:0] spi_wdata;
  logic [1:0]  spi_byte_mask;
  logic [31:0] spi_rdata;
  logic        spi_busy;
  logic        spi_valid;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    input  spi_rdata, spi_busy, spi_valid,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output spi_req, spi_write, spi_addr, spi_wdata, spi_byte_mask
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    output spi_rdata, spi_busy, spi_valid,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  spi_req, spi_write, spi_addr, spi_wdata, spi_byte_mask
  );
endinterface

// File: rtl/spi_sram_bridge.sv
// CPU-to-SPI-SRAM bridge.
// Accepts one CPU request at a time, runs it through a spi_master and
// returns a one-cycle response.  FSM: IDLE -> RUN -> DONE -> IDLE.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : spi_sram_bridge_if.slave (request, response and spi_master side)
// Parameter TIMEOUT_CYCLES: spi_valid wait limit, used only when the macro
// SPI_BRIDGE_TIMEOUT_EN is defined; otherwise RUN waits indefinitely and
// resp_err is constant 0.
module spi_sram_bridge
  import spi_sram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  spi_sram_bridge_if.slave  bus
);

  state_e      state_q, state_d;
  logic        ready_en_q, ready_en_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] swapped_s;
  logic        timeout_hit_s;

  // spi_busy is status only and never steers the FSM
  logic        busy_unused;
  assign busy_unused = bus.spi_busy;

`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
  assign timeout_hit_s  = 1'b0;
`endif

  assign swapped_s = byte_swap(bus.spi_rdata);

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 24'h000000;
      wdata_q    <= 32'h00000000;
      rdata_q    <= 32'h00000000;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      cnt_q      <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ready_en_q <= ready_en_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d    = state_q;
    // ready_en_q stays low for the first edge after reset release, which
    // pushes the earliest accept to the second edge.
    ready_en_d = 1'b1;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
`ifdef SPI_BRIDGE_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ready_en_q && bus.req_valid) begin
          state_d = ST_RUN;
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef SPI_BRIDGE_TIMEOUT_EN
          cnt_d   = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // spi_valid has priority over a timeout in the same cycle
        if (bus.spi_valid) begin
          state_d = ST_DONE;
          rdata_d = we_q ? 32'h00000000 : read_extend(swapped_s, size_q);
`ifdef SPI_BRIDGE_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else if (timeout_hit_s) begin
          state_d = ST_DONE;
          rdata_d = 32'h00000000;
`ifdef SPI_BRIDGE_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
          state_d = ST_RUN;
`ifdef SPI_BRIDGE_TIMEOUT_EN
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state and captured request
  always_comb begin
    bus.spi_write     = we_q;
    bus.spi_addr      = addr_q;
    bus.spi_wdata     = byte_swap(wdata_q);
    bus.spi_byte_mask = size_to_mask(size_q);
    bus.resp_rdata    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready  = ready_en_q;
        bus.spi_req    = 1'b1;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
      end
      ST_RUN: begin
        bus.req_ready  = 1'b0;
        bus.spi_req    = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
      end
      ST_DONE: begin
        bus.req_ready  = 1'b0;
        bus.spi_req    = 1'b1;
        bus.resp_valid = 1'b1;
`ifdef SPI_BRIDGE_TIMEOUT_EN
        bus.resp_err   = err_q;
`else
        bus.resp_err   = 1'b0;
`endif
      end
      default: begin
        bus.req_ready  = 1'b0;
        bus.spi_req    = 1'b1;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Bench for spi_sram_bridge: behavioural spi_master + SPI SRAM on the spi
// side, directed CPU requests, and a scoreboard whose monitor checks each
// spi run start and each response against queued expectations.
module tb_spi_sram_bridge;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_fail;

  spi_sram_bridge_if bus();

  spi_sram_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- spi_master + SRAM model ----------------
  logic [7:0] mem [0:1023];
  logic       mem_init_done;
  logic       act;
  logic       fin;
  logic [3:0] lat;
  logic       stall;
  logic       valid_r;
  logic [31:0] rdata_r;

  assign bus.spi_valid = valid_r;
  assign bus.spi_rdata = rdata_r;
  assign bus.spi_busy  = act && !fin;

  function automatic int mask_bytes(input logic [1:0] m);
    if (m == 2'b00) return 1;
    else if (m == 2'b01) return 2;
    else return 4;
  endfunction

  // Bytes land MSB lane first; unused lanes carry 0xEE filler.
  function automatic logic [31:0] sram_read(input logic [23:0] a, input int nb);
    logic [31:0] r;
    r = 32'hEEEEEEEE;
    for (int i = 0; i < nb; i++) r[8*(3-i) +: 8] = mem[10'(a[9:0] + 10'(i))];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'hA5;
      mem_init_done <= 1'b1;
    end
    if (!reset || bus.spi_req) begin
      act     <= 1'b0;
      fin     <= 1'b0;
      lat     <= 4'd0;
      valid_r <= 1'b0;
    end else if (!act) begin
      act <= 1'b1;
      lat <= 4'd5;
    end else if (lat != 4'd0) begin
      lat <= lat - 4'd1;
    end else if (!fin && !stall) begin
      fin     <= 1'b1;
      valid_r <= 1'b1;
      if (bus.spi_write) begin
        for (int i = 0; i < 4; i++)
          if (i < mask_bytes(bus.spi_byte_mask))
            mem[10'(bus.spi_addr[9:0] + 10'(i))] <= bus.spi_wdata[8*(3-i) +: 8];
      end else begin
        rdata_r <= sram_read(bus.spi_addr, mask_bytes(bus.spi_byte_mask));
      end
    end else begin
      valid_r <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  mask;
    logic [23:0] addr;
    logic [31:0] wdata;
  } spi_t;

  resp_t exp_q[$];
  spi_t  spi_q[$];
  int    accept_cyc;
  int    resp_cyc;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act_v, exp_v);
    end
  endtask

  // Monitor: decoupled from stimulus, checks on every negedge
  initial begin
    logic prev_spi_req;
    logic prev_resp;
    logic had_run;
    int   gap;
    resp_t r;
    spi_t  s;
    prev_spi_req = 1'b1;
    prev_resp    = 1'b0;
    had_run      = 1'b0;
    gap          = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (!bus.spi_req && prev_spi_req) begin
          if (spi_q.size() == 0) begin
            chk("spi_unexpected_run", 64'd1, 64'd0);
          end else begin
            s = spi_q.pop_front();
            chk("spi_cmd", {5'd0, bus.spi_write, bus.spi_byte_mask, bus.spi_addr, bus.spi_wdata},
                {5'd0, s});
          end
          chk("ready_in_run", {63'd0, bus.req_ready}, 64'd0);
          if (had_run) chk("spi_req_gap_ge2", {63'd0, (gap >= 2)}, 64'd1);
          had_run = 1'b1;
          gap     = 0;
        end
        if (bus.resp_valid) begin
          resp_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", 64'd1, 64'd0);
          end else begin
            r = exp_q.pop_front();
            chk("resp", {31'd0, bus.resp_err, bus.resp_rdata}, {31'd0, r});
          end
          chk("ready_in_done", {63'd0, bus.req_ready}, 64'd0);
          chk("resp_one_cycle", {63'd0, prev_resp}, 64'd0);
        end
        prev_spi_req = bus.spi_req;
        prev_resp    = bus.resp_valid;
      end else begin
        prev_spi_req = 1'b1;
        prev_resp    = 1'b0;
      end
      if (bus.spi_req) gap++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [1:0] size, input logic [23:0] addr,
                       input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rd,
                       input logic [1:0] exp_mask, input logic [31:0] exp_spi_wd, input logic hold);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
      bus.req_valid = 1'b0;
    end else begin
      spi_q.push_back('{wr: we, mask: exp_mask, addr: addr, wdata: exp_spi_wd});
      exp_q.push_back('{err: exp_err, rdata: exp_rd});
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      if (!hold) bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("response_timeout", 64'd1, 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_fail = 0;
    cyc = 0;
    stall = 1'b0;
    mem_init_done = 1'b0;
    rdata_r = 32'h0;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = 24'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_spi_req", {63'd0, bus.spi_req}, 64'd1);
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
    chk("rst_resp_rdata", {32'd0, bus.resp_rdata}, 64'd0);
    chk("rst_spi_addr", {40'd0, bus.spi_addr}, 64'd0);
    reset = 1'b1;
    chk("ready_before_first_edge", {63'd0, bus.req_ready}, 64'd0);
    @(negedge clk);
    chk("ready_after_first_edge", {63'd0, bus.req_ready}, 64'd1);

    // word write, then memory image check
    issue(1'b1, 2'd2, 24'h000100, 32'h11223344, 1'b0, 32'h0, 2'b10, 32'h44332211, 1'b0);
    wait_done();
    chk("sram_0x100", {32'd0, mem[256], mem[257], mem[258], mem[259]}, 64'h44332211);
    // reads of the written word
    issue(1'b0, 2'd2, 24'h000100, 32'h0, 1'b0, 32'h11223344, 2'b10, 32'h0, 1'b0);
    wait_done();
    issue(1'b0, 2'd0, 24'h000102, 32'h0, 1'b0, 32'h00000022, 2'b00, 32'h0, 1'b0);
    wait_done();
    issue(1'b0, 2'd1, 24'h000100, 32'h0, 1'b0, 32'h00003344, 2'b01, 32'h0, 1'b0);
    wait_done();
    issue(1'b0, 2'd3, 24'h000100, 32'h0, 1'b0, 32'h11223344, 2'b10, 32'h0, 1'b0);
    wait_done();
    // half write touches exactly two bytes
    issue(1'b1, 2'd1, 24'h000200, 32'hDEADBEEF, 1'b0, 32'h0, 2'b01, 32'hEFBEADDE, 1'b0);
    wait_done();
    chk("sram_0x200", {40'd0, mem[512], mem[513], mem[514]}, 64'hEFBEA5);
    // back-to-back with req_valid held
    issue(1'b0, 2'd2, 24'h000100, 32'h0, 1'b0, 32'h11223344, 2'b10, 32'h0, 1'b1);
    issue(1'b0, 2'd0, 24'h000103, 32'h0, 1'b0, 32'h00000011, 2'b00, 32'h0, 1'b0);
    wait_done();

    // reset in the middle of a run
    issue(1'b0, 2'd2, 24'h000100, 32'h0, 1'b0, 32'h11223344, 2'b10, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_spi_req", {63'd0, bus.spi_req}, 64'd1);
    chk("midrst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    exp_q.delete();
    reset = 1'b1;
    issue(1'b0, 2'd2, 24'h000100, 32'h0, 1'b0, 32'h11223344, 2'b10, 32'h0, 1'b0);
    wait_done();

`ifdef SPI_BRIDGE_TIMEOUT_EN
    // spi_valid never arrives: error response 16 edges after the accept edge
    stall = 1'b1;
    issue(1'b0, 2'd2, 24'h000100, 32'h0, 1'b1, 32'h0, 2'b10, 32'h0, 1'b0);
    wait_done();
    chk("timeout_latency", 64'(resp_cyc - accept_cyc), 64'd16);
    @(negedge clk);
    chk("ready_after_timeout", {63'd0, bus.req_ready}, 64'd1);
    stall = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
